// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 types, frame constants and parity helper for the tx and rx sides
package ps2_pkg;
   typedef enum logic [1:0] {IDLE, SHI, SLO, GAP} ps2_state_t;
   localparam int PS2_FRAME_BITS = 11;
   localparam logic [7:0] PS2_BREAK_CODE = 8'hF0;
   function automatic logic ps2_odd_parity(input logic [7:0] b);
      return ~^b;
   endfunction
endpackage

// File: rtl/ps2_kbd_tx_ser.sv
// ps2_kbd_tx_ser: single 11-bit PS/2 frame serializer with clock divider and bit index
module ps2_frame_ser
   import ps2_pkg::*;
#(
   parameter int CLK_DIV = 50
) (
   input  logic       clk,
   input  logic       clrn,
   input  logic       start,
   input  logic [7:0] data_in,
   output logic       ps2_clk,
   output logic       ps2_data,
   output logic       frame_done
);
   localparam int CW = $clog2(2 * CLK_DIV);
   localparam logic [CW-1:0] HALF_TOP = CW'(CLK_DIV - 1);
   localparam logic [3:0] LAST_BIT = 4'(PS2_FRAME_BITS - 1);
   ps2_state_t state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [3:0] idx_q, idx_d;
   logic [PS2_FRAME_BITS-1:0] frame_q, frame_d;
   logic data_q, data_d, sclk_q, sclk_d;
   logic tick, load;
   assign tick = cnt_q == HALF_TOP;
   assign load = state_q == IDLE && start;
   always_ff @(posedge clk) begin
      if (!clrn) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         frame_q <= '1;
         data_q  <= 1'b1;
         sclk_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         frame_q <= frame_d;
         data_q  <= data_d;
         sclk_q  <= sclk_d;
      end
   end
   always_comb begin
      state_d = state_q;
      if (state_q == IDLE) state_d = start ? SHI : IDLE;
      else if (state_q == SHI) state_d = tick ? SLO : SHI;
      else if (state_q == SLO && tick) state_d = (idx_q == LAST_BIT) ? IDLE : SHI;
   end
   // data only moves on the edge entering SHI, so it is stable across the falling edge
   always_comb begin
      cnt_d   = (state_q == IDLE || tick) ? '0 : cnt_q + 1'b1;
      idx_d   = load ? 4'd0 : (state_q == SLO && tick && idx_q != LAST_BIT) ? idx_q + 4'd1 : idx_q;
      frame_d = load ? {1'b1, ps2_odd_parity(data_in), data_in, 1'b0} : frame_q;
      data_d  = load ? 1'b0 :
                (state_q == SLO && tick) ? ((idx_q == LAST_BIT) ? 1'b1 : frame_q[idx_q + 4'd1]) :
                data_q;
      sclk_d  = state_d != SLO;
   end
   always_comb begin
      ps2_clk    = sclk_q;
      ps2_data   = data_q;
      frame_done = state_q == SLO && tick && idx_q == LAST_BIT;
   end
endmodule

// File: rtl/ps2_kbd_tx.sv
// ps2_kbd_tx: device-side PS/2 keyboard transmitter with optional F0 break prefix
module ps2_kbd_tx
   import ps2_pkg::*;
#(
   parameter int CLK_DIV = 50
) (
   input  logic       clk,
   input  logic       clrn,
   input  logic [7:0] code,
   input  logic       brk,
   input  logic       valid,
   output logic       ready,
   output logic       busy,
   output logic       done,
   output logic       ps2_clk,
   output logic       ps2_data
);
   localparam int CW = $clog2(2 * CLK_DIV);
   localparam logic [CW-1:0] GAP_TOP = CW'(2 * CLK_DIV - 1);
   ps2_state_t state_q, state_d;
   logic [CW-1:0] gcnt_q, gcnt_d;
   logic [7:0] code_q, code_d, ser_byte;
   logic pre_q, pre_d, done_q, done_d;
   logic accept, gap_end, ser_start, frame_done;
   assign accept  = valid && state_q == IDLE;
   assign gap_end = state_q == GAP && gcnt_q == GAP_TOP;
   always_ff @(posedge clk) begin
      if (!clrn) begin
         state_q <= IDLE;
         gcnt_q  <= '0;
         code_q  <= '0;
         pre_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         gcnt_q  <= gcnt_d;
         code_q  <= code_d;
         pre_q   <= pre_d;
         done_q  <= done_d;
      end
   end
   // SHI here covers the whole frame in flight; the serializer splits it into SHI/SLO
   always_comb begin
      state_d = state_q;
      if (state_q == IDLE) state_d = accept ? SHI : IDLE;
      else if (state_q == SHI) state_d = frame_done ? GAP : SHI;
      else if (gap_end) state_d = pre_q ? SHI : IDLE;
   end
   always_comb begin
      gcnt_d    = (state_q == GAP && !gap_end) ? gcnt_q + 1'b1 : '0;
      code_d    = accept ? code : code_q;
      pre_d     = accept ? brk : gap_end ? 1'b0 : pre_q;
      done_d    = gap_end && !pre_q;
      ser_start = accept || (gap_end && pre_q);
      ser_byte  = accept ? (brk ? PS2_BREAK_CODE : code) : code_q;
   end
   always_comb begin
      ready = state_q == IDLE;
      busy  = state_q != IDLE;
      done  = done_q;
   end
   ps2_frame_ser #(.CLK_DIV(CLK_DIV)) u_ser (
      .clk        (clk),
      .clrn       (clrn),
      .start      (ser_start),
      .data_in    (ser_byte),
      .ps2_clk    (ps2_clk),
      .ps2_data   (ps2_data),
      .frame_done (frame_done)
   );
endmodule

// File: tb/tb_ps2_kbd_tx.sv
// tb_ps2_kbd_tx: scoreboard bench sampling frames on the ps2_clk falling edge
module tb_ps2_kbd_tx;
   logic clk, clrn, brk, valid, ready, busy, done, ps2_clk, ps2_data;
   logic [7:0] code;
   logic [10:0] exp_q[$];
   logic [10:0] sh;
   int checks = 0, errors = 0, nb = 0, nfall = 0, f0;
   ps2_kbd_tx #(.CLK_DIV(4)) dut (
      .clk(clk), .clrn(clrn), .code(code), .brk(brk), .valid(valid),
      .ready(ready), .busy(busy), .done(done), .ps2_clk(ps2_clk), .ps2_data(ps2_data)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask
   function automatic logic [10:0] model_frame(input logic [7:0] b);
      int ones = 0;
      logic [10:0] f;
      for (int i = 0; i < 8; i++) ones += int'(b[i]);
      f[0] = 1'b0;
      f[8:1] = b;
      f[9] = (ones % 2 == 0);
      f[10] = 1'b1;
      return f;
   endfunction
   always @(negedge ps2_clk or negedge clrn) begin
      if (!clrn) nb = 0;
      else begin
         sh[nb] = ps2_data;
         nb++;
         nfall++;
         if (nb == 11) begin
            nb = 0;
            chk("sb_nonempty", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) chk("frame", sh, exp_q.pop_front());
         end
      end
   end
   task automatic send(input logic [7:0] c, input logic b);
      @(negedge clk);
      code = c; brk = b; valid = 1;
      if (b) exp_q.push_back(model_frame(8'hF0));
      exp_q.push_back(model_frame(c));
      @(posedge clk); #1;
      valid = 0;
      chk("acc_busy", busy, 1);
      chk("acc_start", ps2_data, 0);
   endtask
   task automatic wait_done(input string tag, input int exp_cyc, input int inj_at);
      int cyc = 0, run = 0, maxrun = 0;
      bit seen = 0;
      while (!seen && cyc < 2000) begin
         @(posedge clk); #1;
         cyc++;
         if (cyc == inj_at) begin valid = 1; code = 8'hAA; end
         if (inj_at > 0 && cyc == inj_at + 3) begin chk({tag, "_ign_rdy"}, ready, 0); valid = 0; end
         if (busy && ps2_clk && ps2_data) run++; else run = 0;
         if (run > maxrun) maxrun = run;
         seen = done;
      end
      chk({tag, "_cyc"}, cyc, exp_cyc);
      chk({tag, "_gap"}, maxrun, 8);
      chk({tag, "_rdy"}, ready, 1);
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end
   initial begin
      int t = 0;
      clk = 0; clrn = 0; valid = 0; code = 0; brk = 0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_lines", {ps2_clk, ps2_data, ready, done, busy}, 5'b11100);
      @(negedge clk) clrn = 1;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         chk("idle", {ps2_clk, ps2_data, ready, done}, 4'b1110);
      end
      f0 = nfall; send(8'h1C, 0); wait_done("make", 96, 0);
      chk("make_falls", nfall - f0, 11);
      f0 = nfall; send(8'h1C, 1); wait_done("brk", 192, 0);
      chk("brk_falls", nfall - f0, 22);
      send(8'h00, 0); wait_done("zero", 96, 0);
      valid = 1; code = 8'hFF; brk = 0;
      exp_q.push_back(model_frame(8'hFF));
      @(posedge clk); #1;
      valid = 0;
      chk("b2b_start", {busy, ps2_data, done}, 3'b100);
      wait_done("b2b", 96, 0);
      send(8'h3C, 0); wait_done("ign", 96, 20);
      send(8'h77, 0);
      while (nb != 6 && t < 1000) begin @(posedge clk); #1; t++; end
      chk("rst_reach", nb, 6);
      chk("rst_clk_low", ps2_clk, 0);
      @(negedge clk) clrn = 0;
      exp_q.delete();
      @(posedge clk); #1;
      chk("midrst_lines", {ps2_clk, ps2_data, ready, done}, 4'b1110);
      @(negedge clk) clrn = 1;
      f0 = nfall; send(8'h5A, 0); wait_done("rec", 96, 0);
      chk("rec_falls", nfall - f0, 11);
      chk("sb_drained", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/ps2_kbd_tx.md
# ps2_kbd_tx

Device-side PS/2 keyboard transmitter: accepts one scancode per handshake and serializes it onto `ps2_clk`/`ps2_data` as standard 11-bit frames. An optional break prefix (`F0`) is sent first. It is the sending end of the PS/2 keyboard path. The simulation harness and the self-test logic use it to drive the receiver, the scancode-to-ASCII lookup and the key buffer with real waveforms instead of poked RAM contents.

## Interface
- `CLK_DIV`, default 50: system-clock cycles per `ps2_clk` half-period. Must be ≥2.
- `clk` in 1: system clock. All logic is on the rising edge.
- `clrn` in 1: reset, synchronous, active-low.
- `code` in 8: scancode to send. Sampled only on acceptance.
- `brk` in 1: when 1, send the `F0` frame first, then `code`. Sampled only on acceptance.
- `valid` in 1: request to send.
- `ready` out 1: high only in IDLE. Reset value 1.
- `busy` out 1: equals `~ready`. Reset value 0.
- `done` out 1: one-cycle pulse when the transaction finishes. Reset value 0.
- `ps2_clk` out 1: PS/2 clock. Idles at 1. Reset value 1.
- `ps2_data` out 1: PS/2 data. Idles at 1. Reset value 1.

## Operation
- Acceptance happens on a rising edge where `valid && ready`. On that edge `code` and `brk` are latched.
- A transaction is one frame (make) or two frames (`brk` = 1: first `F0`, then `code`).
- Frame bit order, index 0..10:
  - bit 0: start bit, 0.
  - bits 1..8: `code[0]..code[7]`, LSB first.
  - bit 9: odd parity, `~^byte`.
  - bit 10: stop bit, 1.
- States:
  - IDLE: waits for acceptance, then goes to SHI with bit index 0 and `ps2_data` set to the start bit.
  - SHI: `ps2_clk` = 1 for `CLK_DIV` cycles, then goes to SLO.
  - SLO: `ps2_clk` = 0 for `CLK_DIV` cycles. Then, if bit index < 10: increment the index, drive the next bit on `ps2_data`, and go to SHI. If bit index = 10: go to GAP.
  - GAP: `ps2_clk` = 1 and `ps2_data` = 1 for `2*CLK_DIV` cycles. Then, if the prefix frame was just sent: load `code`, set index 0, drive 0, go to SHI. Otherwise: go to IDLE and pulse `done`.
- `ps2_data` changes only on the edge that enters SHI, never while `ps2_clk` = 0. The receiver samples on the falling edge of `ps2_clk`.
- `valid` is ignored while `busy`. There is no queuing.
- Counters:
  - Divider: `$clog2(2*CLK_DIV)` bits, saturating reload, no wrap.
  - Bit index: 4 bits, range 0..10.

## Timing
- The edge that accepts a request makes `ps2_data` = 0 in the next cycle. `ready` goes 0 in the same cycle.
- The first falling edge of `ps2_clk` comes `CLK_DIV` cycles after the start bit appears.
- One frame is `22*CLK_DIV` cycles plus a `2*CLK_DIV` gap.
- Acceptance to `done`/`ready` high:
  - make: `24*CLK_DIV` cycles.
  - break: `48*CLK_DIV` cycles.
- `done` is high in the first IDLE cycle, together with `ready` = 1.
- Back-to-back: `valid` high in the `done` cycle is accepted on that edge, so there is no dead cycle.
- Reset low on any edge, including mid-frame:
  - next cycle: state IDLE, `ps2_clk` = 1, `ps2_data` = 1, `ready` = 1, `done` = 0, counters cleared.
  - no partial frame is resumed.
- `valid` held high with no change after completion starts a new identical transaction. This is by design.

## Structure
- Shared package `ps2_pkg` holds:
  - state enum `{IDLE, SHI, SLO, GAP}`.
  - `PS2_FRAME_BITS` = 11.
  - `PS2_BREAK_CODE` = 8'hF0.
  - function `ps2_odd_parity(byte)`.
  - The receiver side uses the same package.
- One sub-module is natural: `ps2_frame_ser`, a single-frame serializer with divider, bit index and load/start/done signals. The top level sequences the prefix frame, the gap and the handshake.

## Test plan
All scenarios use `CLK_DIV` = 4, with a bench PS/2 sampler that samples on the `ps2_clk` falling edge.
- Reset, then idle 20 cycles → `ps2_clk` = 1, `ps2_data` = 1, `ready` = 1, `done` = 0 throughout.
- Send `code` = 8'h1C, `brk` = 0:
  - sampled bits are 0, 0,0,1,1,1,0,0,0, parity 0, stop 1.
  - exactly 11 falling edges.
  - `done` 96 cycles after acceptance.
- Send `code` = 8'h1C, `brk` = 1:
  - first frame is `F0` with parity 1.
  - then a ≥8-cycle idle-high gap.
  - then the `1C` frame.
  - `done` after 192 cycles.
- Send `code` = 8'h00:
  - parity bit 1.
  - then `valid` held high at the `done` cycle with `code` = 8'hFF (parity 1).
  - second frame starts the next cycle with no dead cycle.
- Raise `valid` mid-frame with another code → ignored. The frame on the wire is unchanged and `ready` stays 0.
- Assert `clrn` = 0 during bit 5 → the cycle after, lines are 1/1 and `ready` = 1. A fresh `8'h5A` then transmits correctly.
